// File: rtl/base_logic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : base_logic_pkg
//  Description : Shared definitions for the gate truth-table checker: checker
//                state encoding, vector count and the reference truth tables
//                of the BASE_LOGIC 2-input gate set.
//                Truth tables are indexed {in1,in0}: bit 0 is in1=0,in0=0,
//                bit 1 is in1=0,in0=1, bit 2 is in1=1,in0=0, bit 3 is 1,1.
//  Revision    : 1.0 - initial release
// ============================================================================
package base_logic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam int NUM_VECTORS = 4;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage : base_logic_pkg
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : settle_timer
//  Description : Free-running settle counter. While enabled it counts
//                0..SETTLE-1 and raises tick on the last count, reloading to
//                0 on that same edge. clear forces the count back to 0.
//  Ports       : clk   - rising-edge clock
//                rst   - synchronous active-high reset
//                clear - synchronous count clear (takes priority over en)
//                en    - count enable
//                tick  - high in the cycle whose count equals SETTLE-1
//  Revision    : 1.0 - initial release
// ============================================================================
module settle_timer
    import base_logic_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    // At least one bit so SETTLE = 1 still has a legal (constant-0) counter.
    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_at_last;

    assign w_at_last = (cnt_q == CNT_LAST);
    assign tick      = en && w_at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = w_at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : settle_timer
`default_nettype wire

// File: rtl/gate_truth_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gate_truth_checker
//  Description : Exhaustive truth-table checker for a 2-input combinational
//                gate. On start it walks {in1,in0} through 0..3, holds each
//                vector SETTLE cycles, samples dut_out on the last cycle of
//                each hold and compares the observed table to the expected
//                table captured at start.
//  Ports       : clk       - rising-edge clock
//                rst       - synchronous active-high reset
//                start     - begin a run (only honoured in IDLE)
//                expected  - expected truth table, bit index {in1,in0}
//                in0, in1  - registered stimulus to the gate under test
//                dut_out   - gate output under test
//                busy      - high while vectors are applied
//                done      - one-cycle pulse at the end of a run
//                pass      - result of the last completed run
//                observed  - sampled truth table
//                fail_mask - observed ^ expected, per table entry
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_checker
    import base_logic_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       in0,
    output logic       in1,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] observed,
    output logic [3:0] fail_mask
);

    localparam logic [1:0] IDX_LAST = 2'(NUM_VECTORS - 1);

    chk_state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] expected_q, expected_d;
    logic [3:0] observed_q, observed_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       pass_q, pass_d;
    logic       in0_q, in0_d;
    logic       in1_q, in1_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       w_tick;
    logic       w_run;

    assign w_run = (state_q == RUN);

    // Counter runs only in RUN and is held at 0 everywhere else, so every
    // run starts with a full SETTLE-cycle hold on vector 0.
    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (!w_run),
        .en    (w_run),
        .tick  (w_tick)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        expected_d  = expected_q;
        observed_d  = observed_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    expected_d  = expected;
                    observed_d  = '0;
                    pass_d      = 1'b0;
                    fail_mask_d = '0;
                    idx_d       = '0;
                    state_d     = RUN;
                end
            end

            RUN: begin
                if (w_tick) begin
                    observed_d[idx_q] = dut_out;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                // Result is computed on the edge entering DONE (including the
                // final sample) so pass/fail_mask are valid with the done pulse.
                if (state_d == DONE) begin
                    pass_d      = (observed_d == expected_q);
                    fail_mask_d = observed_d ^ expected_q;
                    done_d      = 1'b1;
                end
            end

            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end

            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so the stimulus changes
        // on the same edge that advances idx.
        busy_d = (state_d == RUN);
        in0_d  = (state_d == RUN) ? idx_d[0] : 1'b0;
        in1_d  = (state_d == RUN) ? idx_d[1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            expected_q  <= '0;
            observed_q  <= '0;
            fail_mask_q <= '0;
            pass_q      <= 1'b0;
            in0_q       <= 1'b0;
            in1_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            expected_q  <= expected_d;
            observed_q  <= observed_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in0       = in0_q;
    assign in1       = in1_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign observed  = observed_q;
    assign fail_mask = fail_mask_q;

endmodule : gate_truth_checker
`default_nettype wire
